// File: rtl/fifo_frame_packetizer_pkg.sv
// Shared definitions for the FIFO frame packetizer: FSM encoding, default
// start-of-frame marker and the byte-lane layout of an 18-bit sample word.
package fifo_frame_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HDR,
        ST_RD,
        ST_WAIT,
        ST_B0,
        ST_B1,
        ST_B2,
        ST_CNT,
        ST_CSUM
    } state_t;

    localparam int         WORD_W      = 18;
    localparam logic [7:0] SOF_DEFAULT = 8'hA5;

    localparam int LANE_HI_MSB  = 17;
    localparam int LANE_HI_LSB  = 16;
    localparam int LANE_MID_MSB = 15;
    localparam int LANE_MID_LSB = 8;
    localparam int LANE_LO_MSB  = 7;

    // Lane 0 carries the two top bits zero-padded, lanes 1 and 2 the lower bytes.
    function automatic logic [7:0] word_lane(input logic [WORD_W-1:0] w, input logic [1:0] lane);
        case (lane)
            2'd0:    word_lane = {6'b0, w[LANE_HI_MSB:LANE_HI_LSB]};
            2'd1:    word_lane = w[LANE_MID_MSB:LANE_MID_LSB];
            default: word_lane = w[LANE_LO_MSB:0];
        endcase
    endfunction

endpackage

// File: rtl/fifo_frame_packetizer_if.sv
// Bus bundle between the packetizer, its upstream sample FIFO and the byte link.
interface fifo_frame_packetizer_if;
    logic        fifo_empty;
    logic [17:0] fifo_q;
    logic        fifo_re;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport master (
        input  fifo_empty, fifo_q, tx_ready,
        output fifo_re, tx_data, tx_valid
    );

    modport slave (
        output fifo_empty, fifo_q, tx_ready,
        input  fifo_re, tx_data, tx_valid
    );
endinterface

// File: rtl/fifo_frame_packetizer_read_port.sv
// FIFO read side: issues the read strobe, tracks the read latency and
// captures the returned word into a holding register.
module fifo_read_port
    import fifo_frame_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_req,
    input  logic              fifo_empty,
    input  logic [WORD_W-1:0] fifo_q,
    output logic              fifo_re,
    output logic              data_ready,
    output logic [WORD_W-1:0] hold_q
);

    logic [RD_LAT-1:0] re_dly;

    assign fifo_re    = rd_req & ~fifo_empty;
    assign data_ready = re_dly[RD_LAT-1];

    // The strobe walks down the delay line; when it reaches the end, Q is valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            re_dly <= '0;
            hold_q <= '0;
        end else begin
            re_dly[0] <= fifo_re;
            for (int i = 1; i < RD_LAT; i++) begin
                re_dly[i] <= re_dly[i-1];
            end
            if (data_ready) begin
                hold_q <= fifo_q;
            end
        end
    end

endmodule

// File: rtl/fifo_frame_packetizer.sv
// Drains 18-bit words from a sample FIFO and serializes them into framed
// byte packets: SOF, three bytes per word, word count, XOR checksum.
module fifo_frame_packetizer
    import fifo_frame_pkg::*;
#(
    parameter int         MAX_BURST = 64,
    parameter int         RD_LAT    = 1,
    parameter logic [7:0] SOF_BYTE  = SOF_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    fifo_frame_packetizer_if.master bus,
    output logic                    frame_active,
    output logic [15:0]             frame_cnt
);

    state_t            state;
    state_t            state_nx;
    logic [7:0]        word_cnt;
    logic [7:0]        csum;
    logic              rd_req;
    logic              data_ready;
    logic [WORD_W-1:0] hold_q;
    logic              byte_acc;

    fifo_read_port #(.RD_LAT(RD_LAT)) u_read_port (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_req     (rd_req),
        .fifo_empty (bus.fifo_empty),
        .fifo_q     (bus.fifo_q),
        .fifo_re    (bus.fifo_re),
        .data_ready (data_ready),
        .hold_q     (hold_q)
    );

    assign byte_acc     = bus.tx_valid & bus.tx_ready;
    assign frame_active = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Byte-presenting states hold tx_data purely from registered state, so
    // the byte cannot change while the link stalls.
    always_comb begin
        state_nx     = state;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        rd_req       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable && !bus.fifo_empty) state_nx = ST_HDR;
            end
            ST_HDR: begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = SOF_BYTE;
                if (bus.tx_ready) state_nx = ST_RD;
            end
            ST_RD: begin
                rd_req   = 1'b1;
                state_nx = ST_WAIT;
            end
            ST_WAIT: begin
                if (data_ready) state_nx = ST_B0;
            end
            ST_B0: begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = word_lane(hold_q, 2'd0);
                if (bus.tx_ready) state_nx = ST_B1;
            end
            ST_B1: begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = word_lane(hold_q, 2'd1);
                if (bus.tx_ready) state_nx = ST_B2;
            end
            ST_B2: begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = word_lane(hold_q, 2'd2);
                if (bus.tx_ready) begin
                    if ((word_cnt == 8'(MAX_BURST - 1)) || bus.fifo_empty) state_nx = ST_CNT;
                    else                                                   state_nx = ST_RD;
                end
            end
            ST_CNT: begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = word_cnt;
                if (bus.tx_ready) state_nx = ST_CSUM;
            end
            ST_CSUM: begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = csum;
                if (bus.tx_ready) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Frame bookkeeping restarts on header entry; the checksum folds in every
    // accepted byte, so by CSUM it covers SOF through COUNT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt  <= '0;
            csum      <= '0;
            frame_cnt <= '0;
        end else if (state == ST_IDLE && state_nx == ST_HDR) begin
            word_cnt <= '0;
            csum     <= '0;
        end else if (byte_acc) begin
            csum <= csum ^ bus.tx_data;
            if (state == ST_B2)   word_cnt  <= word_cnt + 8'd1;
            if (state == ST_CSUM) frame_cnt <= frame_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_fifo_frame_packetizer.sv
// Two packetizers (RD_LAT=1/MAX_BURST=64 and RD_LAT=2/MAX_BURST=5) fed from
// modelled FIFOs, with the byte streams compared against a frame-level model.
module tb_fifo_frame_packetizer;

    localparam int         NDUT = 2;
    localparam logic [7:0] SOF  = 8'hA5;

    logic clk = 1'b0;
    logic rst_n;
    logic enable;
    bit   rand_ready;

    fifo_frame_packetizer_if bus0 ();
    fifo_frame_packetizer_if bus1 ();

    logic        fact [NDUT];
    logic [15:0] fcnt [NDUT];
    logic        emp [NDUT];
    logic [17:0] qv [NDUT];
    logic        ready_r [NDUT];
    logic        re_w [NDUT];
    logic        valid_w [NDUT];
    logic [7:0]  data_w [NDUT];

    logic [17:0] fmem [NDUT][0:511];
    int          head [NDUT];
    int          tail [NDUT];
    logic [7:0]  gmem [NDUT][0:1023];
    logic [7:0]  emem [NDUT][0:1023];
    int          gcnt [NDUT];
    int          ecnt [NDUT];
    int          exp_frames [NDUT];
    int          re_cnt [NDUT];
    int          exp_re [NDUT];
    int          re_bad [NDUT];
    int          stab_bad [NDUT];
    logic        re_seen [NDUT];
    logic        stall_prev [NDUT];
    logic [7:0]  data_prev [NDUT];
    logic        stg_v [NDUT];
    logic [17:0] stg_w [NDUT];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fifo_frame_packetizer #(.MAX_BURST(64), .RD_LAT(1), .SOF_BYTE(8'hA5)) dut0 (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .bus          (bus0),
        .frame_active (fact[0]),
        .frame_cnt    (fcnt[0])
    );

    fifo_frame_packetizer #(.MAX_BURST(5), .RD_LAT(2), .SOF_BYTE(8'hA5)) dut1 (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .bus          (bus1),
        .frame_active (fact[1]),
        .frame_cnt    (fcnt[1])
    );

    assign emp[0] = (head[0] == tail[0]);
    assign emp[1] = (head[1] == tail[1]);
    assign bus0.fifo_empty = emp[0];
    assign bus1.fifo_empty = emp[1];
    assign bus0.fifo_q     = qv[0];
    assign bus1.fifo_q     = qv[1];
    assign bus0.tx_ready   = ready_r[0];
    assign bus1.tx_ready   = ready_r[1];
    assign re_w[0]    = bus0.fifo_re;
    assign re_w[1]    = bus1.fifo_re;
    assign valid_w[0] = bus0.tx_valid;
    assign valid_w[1] = bus1.tx_valid;
    assign data_w[0]  = bus0.tx_data;
    assign data_w[1]  = bus1.tx_data;

    // Upstream FIFO: a strobe seen in a cycle pops at the following edge and the
    // word shows on Q only in the cycle RD_LAT after the strobe; otherwise Q is junk.
    always @(posedge clk) begin : fifo_model
        logic        pv;
        logic [17:0] pw;
        for (int d = 0; d < NDUT; d++) begin
            pv = re_seen[d] && rst_n && (head[d] != tail[d]);
            pw = pv ? fmem[d][head[d]] : 18'($urandom);
            if (pv) head[d] <= head[d] + 1;
            if (d == 0) begin
                qv[d] <= pw;
            end else begin
                stg_v[d] <= pv;
                stg_w[d] <= pw;
                qv[d]    <= stg_v[d] ? stg_w[d] : 18'($urandom);
            end
        end
    end

    // Link side: decide ready mid-cycle, record bytes that will be accepted,
    // and watch strobe legality and stall stability.
    always @(negedge clk) begin : link_monitor
        for (int d = 0; d < NDUT; d++) begin
            if (!rst_n) begin
                re_seen[d]    = 1'b0;
                stall_prev[d] = 1'b0;
                ready_r[d]    = 1'b1;
            end else begin
                re_seen[d] = re_w[d];
                if (re_w[d]) begin
                    re_cnt[d]++;
                    if (emp[d]) re_bad[d]++;
                end
                if (stall_prev[d] && (!valid_w[d] || data_w[d] != data_prev[d])) stab_bad[d]++;
                ready_r[d] = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
                if (valid_w[d] && ready_r[d] && gcnt[d] < 1024) begin
                    gmem[d][gcnt[d]] = data_w[d];
                    gcnt[d]++;
                end
                stall_prev[d] = valid_w[d] && !ready_r[d];
                data_prev[d]  = data_w[d];
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic loadWord(input logic [17:0] w);
        for (int d = 0; d < NDUT; d++) begin
            fmem[d][tail[d]] = w;
            tail[d]++;
            exp_re[d]++;
        end
    endtask

    // Reference: split whatever is queued into frames of at most MAX_BURST
    // words and lay each frame out byte by byte with a running XOR.
    task automatic buildExpected();
        int         idx;
        int         n;
        int         mb;
        logic [7:0] cs;
        logic [7:0] b [3];
        logic [17:0] w;
        for (int d = 0; d < NDUT; d++) begin
            mb  = (d == 0) ? 64 : 5;
            idx = head[d];
            while (idx < tail[d]) begin
                n = tail[d] - idx;
                if (n > mb) n = mb;
                emem[d][ecnt[d]] = SOF;
                ecnt[d]++;
                cs = SOF;
                for (int k = 0; k < n; k++) begin
                    w    = fmem[d][idx + k];
                    b[0] = {6'b0, w[17:16]};
                    b[1] = w[15:8];
                    b[2] = w[7:0];
                    for (int j = 0; j < 3; j++) begin
                        emem[d][ecnt[d]] = b[j];
                        ecnt[d]++;
                        cs = cs ^ b[j];
                    end
                end
                emem[d][ecnt[d]] = 8'(n);
                ecnt[d]++;
                cs = cs ^ 8'(n);
                emem[d][ecnt[d]] = cs;
                ecnt[d]++;
                exp_frames[d]++;
                idx += n;
            end
        end
    endtask

    task automatic runUntilDone(input string name);
        bit done;
        done = 1'b0;
        for (int cyc = 0; cyc < 6000 && !done; cyc++) begin
            @(negedge clk);
            done = 1'b1;
            for (int d = 0; d < NDUT; d++) begin
                if (gcnt[d] < ecnt[d] || fact[d] || head[d] != tail[d]) done = 1'b0;
            end
        end
        checkOutput({name, "_done"}, 32'(done), 32'd1);
    endtask

    task automatic compareAll(input string name);
        for (int d = 0; d < NDUT; d++) begin
            checkOutput($sformatf("%s_d%0d_len", name, d), gcnt[d], ecnt[d]);
            for (int i = 0; i < ecnt[d] && i < gcnt[d]; i++) begin
                checkOutput($sformatf("%s_d%0d_byte%0d", name, d, i), 32'(gmem[d][i]), 32'(emem[d][i]));
            end
            checkOutput($sformatf("%s_d%0d_frame_cnt", name, d), 32'(fcnt[d]), exp_frames[d]);
            checkOutput($sformatf("%s_d%0d_re_pulses", name, d), re_cnt[d], exp_re[d]);
            checkOutput($sformatf("%s_d%0d_re_when_empty", name, d), re_bad[d], 0);
            checkOutput($sformatf("%s_d%0d_stall_stable", name, d), stab_bad[d], 0);
            gcnt[d] = 0;
            ecnt[d] = 0;
        end
    endtask

    task automatic applyStimulus(input string name, input bit rnd);
        buildExpected();
        rand_ready = rnd;
        enable     = 1'b1;
        runUntilDone(name);
        enable     = 1'b0;
        compareAll(name);
    endtask

    task automatic checkResetOutputs(input string name);
        for (int d = 0; d < NDUT; d++) begin
            checkOutput($sformatf("%s_d%0d_valid", name, d), 32'(valid_w[d]), 32'd0);
            checkOutput($sformatf("%s_d%0d_data", name, d), 32'(data_w[d]), 32'd0);
            checkOutput($sformatf("%s_d%0d_re", name, d), 32'(re_w[d]), 32'd0);
            checkOutput($sformatf("%s_d%0d_active", name, d), 32'(fact[d]), 32'd0);
            checkOutput($sformatf("%s_d%0d_fcnt", name, d), 32'(fcnt[d]), 32'd0);
        end
    endtask

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int k;
        for (int d = 0; d < NDUT; d++) begin
            gcnt[d] = 0; ecnt[d] = 0; exp_frames[d] = 0; re_cnt[d] = 0;
            exp_re[d] = 0; re_bad[d] = 0; stab_bad[d] = 0;
        end
        rst_n      = 1'b0;
        enable     = 1'b0;
        rand_ready = 1'b0;
        repeat (3) @(negedge clk);
        checkResetOutputs("por");
        rst_n = 1'b1;
        @(negedge clk);

        loadWord(18'h31234);
        loadWord(18'h000FF);
        applyStimulus("two_words", 1'b0);
        checkOutput("two_words_sof", 32'(gmem[0][0]), 32'hA5);
        checkOutput("two_words_count", 32'(gmem[0][7]), 32'h02);
        checkOutput("two_words_csum", 32'(gmem[0][8]), 32'h7D);

        loadWord(18'h31234);
        loadWord(18'h000FF);
        applyStimulus("two_words_stall", 1'b1);

        loadWord(18'($urandom));
        applyStimulus("single", 1'b1);

        for (int i = 0; i < 70; i++) loadWord(18'($urandom));
        applyStimulus("burst70", 1'b1);
        checkOutput("burst70_count1", 32'(gmem[0][193]), 32'h40);
        checkOutput("burst70_count2", 32'(gmem[0][214]), 32'h06);

        // Asynchronous reset in the middle of the first word of a frame.
        for (int i = 0; i < 3; i++) loadWord(18'($urandom));
        rand_ready = 1'b1;
        enable     = 1'b1;
        for (k = 0; k < 2000 && gcnt[0] < 3; k++) @(negedge clk);
        checkOutput("midrst_reached", 32'(gcnt[0] >= 3), 32'd1);
        @(posedge clk);
        #1;
        rst_n  = 1'b0;
        enable = 1'b0;
        #1;
        checkResetOutputs("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int d = 0; d < NDUT; d++) begin
            gcnt[d] = 0; ecnt[d] = 0; exp_frames[d] = 0;
        end
        @(negedge clk);
        applyStimulus("after_rst", 1'b1);
        checkOutput("after_rst_sof", 32'(gmem[0][0]), 32'hA5);

        // Enable withdrawn once the header is out: the frame still completes.
        for (int i = 0; i < 3; i++) loadWord(18'($urandom));
        buildExpected();
        enable = 1'b1;
        for (k = 0; k < 2000 && (gcnt[0] < 1 || gcnt[1] < 1); k++) @(negedge clk);
        checkOutput("endrop_sof_seen", 32'(gcnt[0] >= 1 && gcnt[1] >= 1), 32'd1);
        enable = 1'b0;
        runUntilDone("endrop");
        checkOutput("endrop_count", 32'(gmem[0][10]), 32'h03);
        compareAll("endrop");

        loadWord(18'($urandom));
        loadWord(18'($urandom));
        repeat (40) @(negedge clk);
        checkOutput("en_hold_bytes", gcnt[0] + gcnt[1], 0);
        for (int d = 0; d < NDUT; d++) begin
            checkOutput($sformatf("en_hold_d%0d_fifo", d), tail[d] - head[d], 2);
            checkOutput($sformatf("en_hold_d%0d_active", d), 32'(fact[d]), 32'd0);
        end
        applyStimulus("reenable", 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_frame_packetizer.md
FIFO_FRAME_PACKETIZER -- requirements
Module: fifo_frame_packetizer

Interface
REQ-001 Parameter MAX_BURST, default 64, max 18-bit words per frame, legal range 1..255.
REQ-002 Parameter RD_LAT, default 1, cycles from RE asserted to Q valid, legal values 1 or 2.
REQ-003 Parameter SOF_BYTE, default 8'hA5, start-of-frame marker.
REQ-004 CLK  input  1  single clock for all logic.
REQ-005 RESET_N  input  1  asynchronous active-low reset.
REQ-006 ENABLE  input  1  permits new frames; a frame in progress always completes.
REQ-007 FIFO_EMPTY  input  1  EMPTY from upstream sample FIFO.
REQ-008 FIFO_Q  input  18  read data from upstream FIFO.
REQ-009 FIFO_RE  output  1  active-high read strobe to FIFO.
REQ-010 TX_DATA  output  8  byte stream toward comm link.
REQ-011 TX_VALID  output  1  TX_DATA valid.
REQ-012 TX_READY  input  1  consumer accepts byte when TX_VALID and TX_READY are both high.
REQ-013 FRAME_ACTIVE  output  1  high from HDR entry until CSUM byte accepted.
REQ-014 FRAME_CNT  output  16  completed-frame counter, wraps 16'hFFFF->0.

Function
REQ-015 Frame format SHALL be: SOF_BYTE, then 3 bytes per word ({6'b0,Q[17:16]}, Q[15:8], Q[7:0]), then COUNT byte (words in frame), then CSUM byte = XOR of all prior frame bytes including SOF and COUNT.
REQ-016 FSM states: IDLE, HDR, RD, WAIT, B0, B1, B2, CNT, CSUM.
REQ-017 IDLE->HDR when ENABLE=1 and FIFO_EMPTY=0; otherwise stay.
REQ-018 HDR presents SOF_BYTE; on accept ->RD.
REQ-019 RD asserts FIFO_RE for exactly one cycle (FIFO_EMPTY=0 guaranteed by entry condition) ->WAIT.
REQ-020 WAIT lasts RD_LAT cycles; FIFO_Q captured into holding register on the last WAIT cycle ->B0.
REQ-021 B0->B1->B2 each advance only on byte accept.
REQ-022 On B2 accept: word count incremented; if count=MAX_BURST or FIFO_EMPTY=1 ->CNT, else ->RD.
REQ-023 CNT presents word count; on accept ->CSUM; CSUM on accept ->IDLE, FRAME_CNT increments.
REQ-024 FIFO_RE SHALL never assert outside RD, and never when FIFO_EMPTY=1.
REQ-025 TX_DATA SHALL stay stable while TX_VALID=1 and TX_READY=0; TX_VALID low in IDLE, RD, WAIT.
REQ-026 Checksum accumulator cleared on HDR entry, updated on every accepted byte.
REQ-027 ENABLE deassert mid-frame SHALL NOT truncate frame; next frame starts only after ENABLE=1 again.
REQ-028 Empty frames SHALL never be emitted (COUNT always 1..MAX_BURST).

Reset
REQ-029 RESET_N low asynchronously forces: state IDLE, FIFO_RE=0, TX_VALID=0, TX_DATA=8'h00, FRAME_ACTIVE=0, FRAME_CNT=0, word count=0, checksum=0, holding register=0.
REQ-030 Reset mid-frame abandons the frame; no completion bytes emitted after release.

Structure
REQ-031 Package fifo_frame_pkg SHALL hold the FSM state encoding, default SOF_BYTE and byte-lane slice constants.
REQ-032 Sub-module fifo_read_port SHALL own RE generation, RD_LAT delay and capture register; FSM/serializer remain top-level.

Verification
REQ-033 FIFO holds 18'h31234, 18'h000FF, TX_READY=1 -> bytes A5,03,12,34,00,00,FF,02,7D; FRAME_CNT=1.
REQ-034 FIFO holds 70 words, MAX_BURST=64 -> first frame COUNT=8'h40, second COUNT=8'h06, FRAME_CNT=2.
REQ-035 TX_READY toggled randomly during REQ-033 -> identical byte sequence, TX_DATA stable while stalled.
REQ-036 RD_LAT=2 with REQ-033 stimulus -> identical output; exactly 2 FIFO_RE pulses, none with FIFO_EMPTY=1.
REQ-037 RESET_N pulsed low after B1 of first word -> all outputs at reset values immediately; next frame begins with A5 and correct CSUM.
REQ-038 ENABLE dropped after HDR accept with 3 words queued -> full frame COUNT=03 emitted, then IDLE until ENABLE=1.
